// File: rtl/insn_fetch_seq.sv
// Instruction fetch sequencer: one current word plus one prefetch word,
// steps left/right halves to the execute unit, redirects and squashes.
module insn_fetch_seq #(
  parameter int AW = 20,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_addr,
  input  logic          jmp_right,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic [DW-1:0] dc,
  output logic          tkk,
  output logic [AW-1:0] ins_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [AW-1:0] mem_addr_n, ins_addr_n;
  logic [DW-1:0] pf, pf_n, dc_n;
  logic          pf_valid, pf_valid_n;
  logic          squash, squash_n;
  logic          mem_req_n, tkk_n;
  logic          ack, take;

  assign ack       = mem_req & mem_ack;
  assign ins_valid = (state == RUN);
  assign take      = ins_valid & ins_ready;

  // Next state: jump beats consume and ack; squashed data is dropped.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    dc_n       = dc;
    tkk_n      = tkk;
    ins_addr_n = ins_addr;
    pf_n       = pf;
    pf_valid_n = pf_valid;
    squash_n   = squash;
    if (jmp_valid) begin
      state_n    = FETCH;
      pc_n       = jmp_addr;
      tkk_n      = jmp_right;
      pf_valid_n = 1'b0;
      if (mem_req && !ack) begin
        squash_n = 1'b1;
      end else begin
        squash_n   = 1'b0;
        mem_req_n  = 1'b1;
        mem_addr_n = jmp_addr;
      end
    end else begin
      unique case (state)
        IDLE: ;
        FETCH: begin
          if (ack && squash) begin
            squash_n   = 1'b0;
            mem_req_n  = 1'b1;
            mem_addr_n = pc;
          end else if (ack) begin
            dc_n       = mem_rdata;
            ins_addr_n = mem_addr;
            pc_n       = pc + AW'(1);
            mem_req_n  = 1'b0;
            state_n    = RUN;
          end else if (!mem_req) begin
            mem_req_n  = 1'b1;
            mem_addr_n = pc;
          end
        end
        RUN: begin
          if (take && tkk) begin
            tkk_n = 1'b0;
            if (pf_valid) begin
              dc_n       = pf;
              ins_addr_n = ins_addr + AW'(1);
              pf_valid_n = 1'b0;
            end else if (ack) begin
              dc_n       = mem_rdata;
              ins_addr_n = mem_addr;
              pc_n       = pc + AW'(1);
              mem_req_n  = 1'b0;
            end else begin
              state_n = FETCH;
            end
          end else begin
            if (take) tkk_n = 1'b1;
            if (ack) begin
              pf_n       = mem_rdata;
              pf_valid_n = 1'b1;
              pc_n       = pc + AW'(1);
              mem_req_n  = 1'b0;
            end else if (!mem_req && !pf_valid) begin
              mem_req_n  = 1'b1;
              mem_addr_n = pc;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      dc       <= '0;
      tkk      <= 1'b0;
      ins_addr <= '0;
      pf       <= '0;
      pf_valid <= 1'b0;
      squash   <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
      dc       <= dc_n;
      tkk      <= tkk_n;
      ins_addr <= ins_addr_n;
      pf       <= pf_n;
      pf_valid <= pf_valid_n;
      squash   <= squash_n;
    end
  end

endmodule

// File: tb/tb_insn_fetch_seq.sv
// Bench for insn_fetch_seq: memory responder, jump scoreboard,
// directed scenarios then a randomized run.
`timescale 1ns/1ps
module tb_insn_fetch_seq;
  localparam int AW = 20;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          jmp_valid = 1'b0;
  logic [AW-1:0] jmp_addr = '0;
  logic          jmp_right = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          ins_valid;
  logic          ins_ready = 1'b0;
  logic [DW-1:0] dc;
  logic          tkk;
  logic [AW-1:0] ins_addr;

  int total = 0;
  int bad = 0;

  insn_fetch_seq #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .jmp_valid(jmp_valid), .jmp_addr(jmp_addr),
    .jmp_right(jmp_right),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .dc(dc), .tkk(tkk), .ins_addr(ins_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {12'hA5C, a, ~a, 12'h3C5};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Memory: lat<0 random 0..3, else fixed; ack_now forces an ack.
  int            lat = 0;
  bit            ack_now = 0;
  bit            busy = 0;
  int            cnt = 0;
  int            nreq = 0;
  logic [AW-1:0] req_q[$];

  initial forever begin
    @(posedge clk);
    #2;
    mem_ack = 1'b0;
    if (!busy && mem_req) begin
      busy = 1;
      nreq++;
      req_q.push_back(mem_addr);
      cnt = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
    end
    if (busy) begin
      if (cnt == 0 || ack_now) begin
        mem_ack   = 1'b1;
        mem_rdata = word(mem_addr);
        busy      = 0;
        ack_now   = 0;
      end else begin
        cnt--;
      end
    end
  end

  // Scoreboard: jumps queue their target; consumes follow the
  // sequential half stream from the latest target.
  typedef struct packed {
    logic [AW-1:0] a;
    logic          r;
  } jmp_t;
  jmp_t          exp_q[$];
  logic [AW-1:0] exp_addr = '0;
  logic          exp_half = 1'b0;
  bit            exp_live = 0;
  int            ncons = 0;
  logic          pv = 0, pr = 0, pj = 0, preq = 0, pack = 0;
  logic [DW-1:0] pdc = '0;
  logic          ptkk = 0;
  logic [AW-1:0] pia = '0, paddr = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_live = 0;
      exp_q.delete();
      pv = 0;
      preq = 0;
    end else begin
      if (pv && !pr && !pj) begin
        chk("hold_valid", 64'(ins_valid), 64'(1));
        chk("hold_dc", dc, pdc);
        chk("hold_tkk", 64'(tkk), 64'(ptkk));
        chk("hold_addr", 64'(ins_addr), 64'(pia));
      end
      if (preq && !pack) begin
        chk("req_held", 64'(mem_req), 64'(1));
        chk("req_addr_held", 64'(mem_addr), 64'(paddr));
      end
      if (ins_valid && ins_ready) begin
        ncons++;
        if (!exp_live) begin
          total++;
          bad++;
          $display("FAIL cons_unexpected: got addr %h want none",
                   ins_addr);
        end else begin
          chk("cons_addr", 64'(ins_addr), 64'(exp_addr));
          chk("cons_half", 64'(tkk), 64'(exp_half));
          chk("cons_word", dc, word(exp_addr));
          if (exp_half) exp_addr = exp_addr + 1'b1;
          exp_half = ~exp_half;
        end
      end
      if (jmp_valid && exp_q.size() > 0) begin
        jmp_t j;
        j = exp_q.pop_front();
        exp_addr = j.a;
        exp_half = j.r;
        exp_live = 1;
      end
      pv = ins_valid; pr = ins_ready; pj = jmp_valid;
      pdc = dc; ptkk = tkk; pia = ins_addr;
      preq = mem_req; pack = mem_ack; paddr = mem_addr;
    end
  end

  task automatic do_jump(input logic [AW-1:0] a, input logic r);
    jmp_valid = 1'b1;
    jmp_addr  = a;
    jmp_right = r;
    exp_q.push_back('{a, r});
    step();
    jmp_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int i = 0;
    while (!ins_valid && i < lim) begin
      step();
      i++;
    end
    chk(nm, 64'(ins_valid), 64'(1));
  endtask

  task automatic wait_reqn(input string nm, input int n, input int lim);
    int i = 0;
    while (req_q.size() <= n && i < lim) begin
      step();
      i++;
    end
    chk(nm, 64'(req_q.size() > n), 64'(1));
  endtask

  task automatic wait_req_at(input string nm, input logic [AW-1:0] a,
                             input int lim);
    int i = 0;
    while (!(mem_req && mem_addr == a) && i < lim) begin
      step();
      i++;
    end
    chk(nm, 64'(mem_req && mem_addr == a), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n0, c0, r0;
    bit sawack;
    lat = 2;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_req", 64'(mem_req), 64'(0));
    chk("rst_maddr", 64'(mem_addr), 64'(0));
    chk("rst_valid", 64'(ins_valid), 64'(0));
    chk("rst_dc", dc, 64'(0));
    chk("rst_tkk", 64'(tkk), 64'(0));
    chk("rst_iaddr", 64'(ins_addr), 64'(0));
    reset_n = 1'b1;
    step();
    chk("idle_req", 64'(mem_req), 64'(0));

    // first fetch after reset
    do_jump(20'h00010, 1'b0);
    chk("t1_req", 64'(mem_req), 64'(1));
    chk("t1_addr", 64'(mem_addr), 64'(20'h00010));
    sawack = 0;
    for (int i = 0; i < 20 && !ins_valid; i++) begin
      sawack = mem_ack;
      step();
    end
    chk("t1_valid", 64'(ins_valid), 64'(1));
    chk("t1_ack_prev", 64'(sawack), 64'(1));
    chk("t1_tkk", 64'(tkk), 64'(0));
    chk("t1_iaddr", 64'(ins_addr), 64'(20'h00010));

    // stall: one prefetch, outputs stable
    lat = 0;
    n0 = nreq;
    repeat (5) step();
    chk("t5_nreq", 64'(nreq - n0), 64'(1));
    chk("t5_req_low", 64'(mem_req), 64'(0));
    chk("t5_dc", dc, word(20'h00010));
    chk("t5_tkk", 64'(tkk), 64'(0));

    // streaming with 1-cycle memory
    c0 = ncons;
    ins_ready = 1'b1;
    repeat (4) step();
    ins_ready = 1'b0;
    chk("t2_nobubble", 64'(ncons - c0), 64'(4));

    // jump to right half while a prefetch is in flight
    lat = 3;
    for (int i = 0; i < 10 && !mem_req; i++) step();
    chk("t3_inflight", 64'(mem_req), 64'(1));
    r0 = req_q.size();
    do_jump(20'h00200, 1'b1);
    wait_reqn("t3_newreq", r0, 20);
    if (req_q.size() > r0)
      chk("t3_addr", 64'(req_q[r0]), 64'(20'h00200));
    wait_valid("t3_valid", 20);
    chk("t3_tkk", 64'(tkk), 64'(1));
    chk("t3_iaddr", 64'(ins_addr), 64'(20'h00200));
    wait_reqn("t3_pfreq", r0 + 1, 20);
    if (req_q.size() > r0 + 1)
      chk("t3_pfaddr", 64'(req_q[r0 + 1]), 64'(20'h00201));
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;

    // jump, ack and consume in one cycle
    lat = 100;
    do_jump(20'h00300, 1'b0);
    wait_req_at("t4_req300", 20'h00300, 30);
    ack_now = 1;
    wait_valid("t4_valid300", 10);
    wait_req_at("t4_req301", 20'h00301, 10);
    ack_now = 1;
    step();
    chk("t4_ack", 64'(mem_ack), 64'(1));
    ins_ready = 1'b1;
    do_jump(20'h00400, 1'b0);
    ins_ready = 1'b0;
    chk("t4_req", 64'(mem_req), 64'(1));
    chk("t4_addr", 64'(mem_addr), 64'(20'h00400));
    for (int i = 0; i < 3; i++) begin
      chk("t4_novalid", 64'(ins_valid), 64'(0));
      step();
    end
    ack_now = 1;
    wait_valid("t4_valid400", 10);
    chk("t4_iaddr", 64'(ins_addr), 64'(20'h00400));
    chk("t4_dc", dc, word(20'h00400));

    // wrap of pc, then reset mid-request
    lat = 0;
    if (busy) ack_now = 1;
    r0 = req_q.size();
    do_jump(20'hFFFFF, 1'b0);
    wait_valid("t6_valid", 40);
    wait_reqn("t6_wrapreq", r0 + 1, 20);
    if (req_q.size() > r0 + 1) begin
      chk("t6_addr0", 64'(req_q[r0]), 64'(20'hFFFFF));
      chk("t6_addr1", 64'(req_q[r0 + 1]), 64'(20'h00000));
    end
    lat = 100;
    ins_ready = 1'b1;
    repeat (3) step();
    ins_ready = 1'b0;
    chk("t6_iaddr", 64'(ins_addr), 64'(20'h00000));
    for (int i = 0; i < 10 && !mem_req; i++) step();
    chk("t6_pending", 64'(mem_req), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("t6_rst_req", 64'(mem_req), 64'(0));
    chk("t6_rst_valid", 64'(ins_valid), 64'(0));
    step();
    reset_n = 1'b1;
    ack_now = 1;
    step();
    chk("t6_stale_ack", 64'(mem_ack), 64'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_idle_req", 64'(mem_req), 64'(0));
      chk("t6_idle_valid", 64'(ins_valid), 64'(0));
    end

    // randomized run
    lat = -1;
    c0 = ncons;
    do_jump(AW'($urandom), 1'($urandom));
    for (int i = 0; i < 3000; i++) begin
      ins_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 1) == 1)
          do_jump(AW'($urandom), 1'($urandom));
        else
          do_jump(20'hFFFFD + AW'($urandom_range(0, 3)),
                  1'($urandom));
      end else begin
        step();
      end
    end
    ins_ready = 1'b0;
    repeat (5) step();
    chk("rnd_q_empty", 64'(exp_q.size()), 64'(0));
    chk("rnd_progress", 64'((ncons - c0) > 200), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
